sb_trans_rx: RTL and testbench

Electrical-side sideband transaction receiver that consumes the `sbtx` serial stream produced by `logical_layer` and recovers complete sideband AT transactions. It deserializes UART-style symbols at one bit per `sb_clk` cycle and removes DLE framing and stuffing. Each transaction is presented as a single-cycle strobe with its STX code, unstuffed payload and length. It sits directly downstream of the logical layer's sideband transmitter, as the link-partner receive path in the electrical layer model and in loopback configurations.

---
 rtl/sb_trans_rx_pkg.sv | 30 +++
 rtl/sb_trans_rx_if.sv | 36 +++
 rtl/sb_uart_rx.sv | 72 +++++++
 rtl/sb_trans_rx.sv | 153 +++++++++++++++
 tb/tb_sb_trans_rx.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sb_trans_rx_pkg.sv
// -----------------------------------------------------------------------------
// sb_pkg
// Shared definitions for the sideband transaction receiver:
//   - DLE framing byte values (DLE, STX_CMD, STX_RSP, ETX)
//   - bit-level and frame-level FSM state encodings
//   - default maximum unstuffed payload size
// -----------------------------------------------------------------------------
package sb_pkg;

  localparam logic [7:0] DLE     = 8'hFE;
  localparam logic [7:0] STX_CMD = 8'h05;
  localparam logic [7:0] STX_RSP = 8'h04;
  localparam logic [7:0] ETX     = 8'h40;

  localparam int MAX_PAYLOAD_DEF = 16;

  typedef enum logic [1:0] {
    BIT_IDLE,
    BIT_DATA,
    BIT_STOP
  } bit_state_t;

  typedef enum logic [1:0] {
    HUNT,
    GOT_DLE,
    IN_FRAME,
    IN_DLE
  } frame_state_t;

endpackage

// File: rtl/sb_trans_rx_if.sv
// -----------------------------------------------------------------------------
// sb_trans_rx_if
// Bundles the serial input and the recovered-transaction outputs of
// sb_trans_rx.
//   sbtx_i         serial line, idles high
//   trans_valid_o  one-cycle pulse on a good transaction
//   trans_stx_o    STX code of the last good transaction
//   trans_len_o    payload byte count of the last good transaction
//   trans_data_o   payload, byte i at [8i+7:8i], zero beyond len
//   trans_err_o    one-cycle pulse on a discarded transaction
// Modports: master = line driver / transaction consumer, slave = receiver.
// -----------------------------------------------------------------------------
interface sb_trans_rx_if
  import sb_pkg::*;
#(
  parameter int MAX_PAYLOAD = MAX_PAYLOAD_DEF
);

  logic                     sbtx_i;
  logic                     trans_valid_o;
  logic [7:0]               trans_stx_o;
  logic [4:0]               trans_len_o;
  logic [8*MAX_PAYLOAD-1:0] trans_data_o;
  logic                     trans_err_o;

  modport master (
    output sbtx_i,
    input  trans_valid_o, trans_stx_o, trans_len_o, trans_data_o, trans_err_o
  );

  modport slave (
    input  sbtx_i,
    output trans_valid_o, trans_stx_o, trans_len_o, trans_data_o, trans_err_o
  );

endinterface

// File: rtl/sb_uart_rx.sv
// -----------------------------------------------------------------------------
// sb_uart_rx
// Bit-level deserializer: one bit per sb_clk, start 0, 8 data bits LSB first,
// stop 1.
// Ports:
//   sb_clk       clock, one serial bit per cycle
//   rst          synchronous active-high reset
//   sbtx_i       serial line
//   byte_o       last deserialized byte
//   byte_stb_o   high in the stop-bit sample cycle when the stop bit is 1
//   frame_err_o  high in the stop-bit sample cycle when the stop bit is 0
// The strobes are combinational so the frame FSM can register its result on
// the same edge that samples the stop bit.
// -----------------------------------------------------------------------------
module sb_uart_rx
  import sb_pkg::*;
(
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       sbtx_i,
  output logic [7:0] byte_o,
  output logic       byte_stb_o,
  output logic       frame_err_o
);

  bit_state_t r_state, w_state_next;
  logic [2:0] r_bit_cnt, w_bit_cnt_next;
  logic [7:0] r_shift, w_shift_next;

  always_ff @(posedge sb_clk) begin
    if (rst) begin
      r_state   <= BIT_IDLE;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_shift   <= w_shift_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next   = r_shift;
    byte_stb_o     = 1'b0;
    frame_err_o    = 1'b0;
    case (r_state)
      BIT_IDLE: begin
        if (!sbtx_i) begin
          w_state_next   = BIT_DATA;
          w_bit_cnt_next = 3'd0;
        end
      end
      BIT_DATA: begin
        // LSB arrives first, so shift in from the top.
        w_shift_next   = {sbtx_i, r_shift[7:1]};
        w_bit_cnt_next = r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) w_state_next = BIT_STOP;
      end
      BIT_STOP: begin
        byte_stb_o   = sbtx_i;
        frame_err_o  = ~sbtx_i;
        w_state_next = BIT_IDLE;
      end
      default: w_state_next = BIT_IDLE;
    endcase
  end

  assign byte_o = r_shift;

endmodule

// File: rtl/sb_trans_rx.sv
// -----------------------------------------------------------------------------
// sb_trans_rx
// Recovers DLE-framed sideband transactions from the serial stream:
// FE STX payload... FE 40, with payload FE sent as FE FE.
// Ports:
//   sb_clk  clock, one serial bit per cycle
//   rst     synchronous active-high reset
//   bus     sb_trans_rx_if.slave (serial in, transaction outputs)
// Output registers change only on a good transaction; errors only pulse.
// -----------------------------------------------------------------------------
module sb_trans_rx
  import sb_pkg::*;
#(
  parameter int MAX_PAYLOAD = MAX_PAYLOAD_DEF
)(
  input  logic         sb_clk,
  input  logic         rst,
  sb_trans_rx_if.slave bus
);

  localparam logic [4:0] MAX_CNT = 5'(MAX_PAYLOAD);

  logic [7:0] w_byte;
  logic       w_byte_stb;
  logic       w_frame_err;

  sb_uart_rx u_uart (
    .sb_clk      (sb_clk),
    .rst         (rst),
    .sbtx_i      (bus.sbtx_i),
    .byte_o      (w_byte),
    .byte_stb_o  (w_byte_stb),
    .frame_err_o (w_frame_err)
  );

  frame_state_t r_state, w_state_next;
  logic [4:0]   r_count, w_count_next;
  logic [7:0]   r_stx_lat, w_stx_lat_next;
  logic         r_valid, r_err, r_good_dummy;
  logic [7:0]   r_stx;
  logic [4:0]   r_len;
  logic         w_store_req, w_wr_en, w_good, w_err;
  logic [7:0]   w_store_byte;

  always_comb begin
    w_state_next   = r_state;
    w_count_next   = r_count;
    w_stx_lat_next = r_stx_lat;
    w_store_req    = 1'b0;
    w_store_byte   = w_byte;
    w_wr_en        = 1'b0;
    w_good         = 1'b0;
    w_err          = 1'b0;
    if (w_byte_stb) begin
      case (r_state)
        HUNT: if (w_byte == DLE) w_state_next = GOT_DLE;
        GOT_DLE: begin
          if (w_byte == STX_CMD || w_byte == STX_RSP) begin
            w_stx_lat_next = w_byte;
            w_count_next   = 5'd0;
            w_state_next   = IN_FRAME;
          end else if (w_byte != DLE) begin
            w_state_next = HUNT;
          end
        end
        IN_FRAME: begin
          if (w_byte == DLE) w_state_next = IN_DLE;
          else               w_store_req  = 1'b1;
        end
        IN_DLE: begin
          w_state_next = HUNT;
          if (w_byte == DLE) begin
            // Stuffed DLE: payload byte 0xFE.
            w_store_req  = 1'b1;
            w_store_byte = DLE;
            w_state_next = IN_FRAME;
          end else if (w_byte == ETX) begin
            // Count can never exceed MAX_CNT here, so only zero is bad.
            if (r_count == 5'd0) w_err  = 1'b1;
            else                 w_good = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        default: w_state_next = HUNT;
      endcase
      // Overflow is caught before the increment, so the count never wraps.
      if (w_store_req) begin
        if (r_count == MAX_CNT) begin
          w_err        = 1'b1;
          w_state_next = HUNT;
        end else begin
          w_wr_en      = 1'b1;
          w_count_next = r_count + 5'd1;
        end
      end
    end else if (w_frame_err && r_state != HUNT) begin
      w_err        = 1'b1;
      w_state_next = HUNT;
    end
  end

  always_ff @(posedge sb_clk) begin
    if (rst) begin
      r_state      <= HUNT;
      r_count      <= 5'd0;
      r_stx_lat    <= 8'h00;
      r_valid      <= 1'b0;
      r_err        <= 1'b0;
      r_stx        <= 8'h00;
      r_len        <= 5'd0;
      r_good_dummy <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_count      <= w_count_next;
      r_stx_lat    <= w_stx_lat_next;
      r_valid      <= w_good;
      r_err        <= w_err;
      r_good_dummy <= 1'b0;
      if (w_good) begin
        r_stx <= r_stx_lat;
        r_len <= r_count;
      end
    end
  end

  // Per-byte payload buffer and output register; output bytes at or beyond
  // the completed count are forced to zero so stale bytes never leak.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_PAYLOAD; gi++) begin : g_byte
      localparam logic [4:0] IDX = 5'(gi);
      logic [7:0] r_buf_byte;
      logic [7:0] r_out_byte;
      always_ff @(posedge sb_clk) begin
        if (rst) begin
          r_buf_byte <= 8'h00;
          r_out_byte <= 8'h00;
        end else begin
          if (w_wr_en && r_count == IDX) r_buf_byte <= w_store_byte;
          if (w_good) r_out_byte <= (IDX < r_count) ? r_buf_byte : 8'h00;
        end
      end
      assign bus.trans_data_o[8*gi +: 8] = r_out_byte;
    end
  endgenerate

  assign bus.trans_valid_o = r_valid;
  assign bus.trans_err_o   = r_err | r_good_dummy;
  assign bus.trans_stx_o   = r_stx;
  assign bus.trans_len_o   = r_len;

endmodule

// File: tb/tb_sb_trans_rx.sv
// -----------------------------------------------------------------------------
// tb_sb_trans_rx
// Drives serial frames into sb_trans_rx and checks recovered transactions
// against payloads built by the bench (directed and $urandom frames).
// -----------------------------------------------------------------------------
module tb_sb_trans_rx;

  localparam int MP = 16;

  typedef logic [7:0] bq_t [$];
  typedef struct {
    logic [7:0]      stx;
    logic [4:0]      len;
    logic [8*MP-1:0] data;
    int              cyc;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  sb_trans_rx_if #(.MAX_PAYLOAD(MP)) bus();

  sb_trans_rx #(.MAX_PAYLOAD(MP)) dut (
    .sb_clk (clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rec_t vq[$];
  int   eq[$];
  int   both_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_stop_cyc = 0;

  // Pulse recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.trans_valid_o)
      vq.push_back('{bus.trans_stx_o, bus.trans_len_o, bus.trans_data_o, cyc});
    if (bus.trans_err_o) eq.push_back(cyc);
    if (bus.trans_valid_o && bus.trans_err_o) both_cnt++;
  end

  task automatic send_bit(input logic b);
    bus.sbtx_i = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    last_stop_cyc = cyc;
  endtask

  task automatic send_bytes(input bq_t q);
    foreach (q[i]) send_byte(q[i], 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  // Reference encoder: wrap payload in DLE framing, doubling any 0xFE.
  function automatic bq_t build_frame(input logic [7:0] stx, input bq_t pl);
    bq_t f;
    f.push_back(8'hFE);
    f.push_back(stx);
    foreach (pl[i]) begin
      f.push_back(pl[i]);
      if (pl[i] == 8'hFE) f.push_back(8'hFE);
    end
    f.push_back(8'hFE);
    f.push_back(8'h40);
    return f;
  endfunction

  function automatic logic [8*MP-1:0] pack_pl(input bq_t pl);
    logic [8*MP-1:0] d = '0;
    foreach (pl[i]) d[8*i +: 8] = pl[i];
    return d;
  endfunction

  task automatic test_reset();
    n_checks++;
    if (bus.trans_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.trans_valid_o); end
    n_checks++;
    if (bus.trans_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.trans_err_o); end
    n_checks++;
    if (bus.trans_stx_o !== 8'h00) begin n_fail++; $display("FAIL reset_stx got %h want 00", bus.trans_stx_o); end
    n_checks++;
    if (bus.trans_len_o !== 5'd0) begin n_fail++; $display("FAIL reset_len got %0d want 0", bus.trans_len_o); end
    n_checks++;
    if (bus.trans_data_o !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", bus.trans_data_o); end
    $display("reset: outputs checked");
  endtask

  task automatic test_good_cmd();
    bq_t f = '{8'hFE, 8'h05, 8'h12, 8'h34, 8'hFE, 8'h40};
    int stop_cyc;
    vq.delete(); eq.delete();
    send_bytes(f);
    stop_cyc = last_stop_cyc;
    idle(3);
    n_checks++;
    if (vq.size() !== 1) begin n_fail++; $display("FAIL good_cmd_count got %0d want 1", vq.size()); end
    else begin
      n_checks++;
      if (vq[0].stx !== 8'h05) begin n_fail++; $display("FAIL good_cmd_stx got %h want 05", vq[0].stx); end
      n_checks++;
      if (vq[0].len !== 5'd2) begin n_fail++; $display("FAIL good_cmd_len got %0d want 2", vq[0].len); end
      n_checks++;
      if (vq[0].data !== 128'h3412) begin n_fail++; $display("FAIL good_cmd_data got %h want 3412", vq[0].data); end
      n_checks++;
      if (vq[0].cyc !== stop_cyc) begin n_fail++; $display("FAIL good_cmd_latency got cyc %0d want %0d", vq[0].cyc, stop_cyc); end
    end
    n_checks++;
    if (eq.size() !== 0) begin n_fail++; $display("FAIL good_cmd_err got %0d pulses want 0", eq.size()); end
    $display("good_cmd: FE 05 12 34 FE 40 -> %0d valid pulses", vq.size());
  endtask

  task automatic test_stuffing();
    bq_t f = '{8'hFE, 8'h04, 8'hFE, 8'hFE, 8'h01, 8'hFE, 8'h40};
    vq.delete(); eq.delete();
    send_bytes(f);
    idle(3);
    n_checks++;
    if (vq.size() !== 1) begin n_fail++; $display("FAIL stuff_count got %0d want 1", vq.size()); end
    else begin
      n_checks++;
      if (vq[0].stx !== 8'h04) begin n_fail++; $display("FAIL stuff_stx got %h want 04", vq[0].stx); end
      n_checks++;
      if (vq[0].len !== 5'd2) begin n_fail++; $display("FAIL stuff_len got %0d want 2", vq[0].len); end
      n_checks++;
      if (vq[0].data !== 128'h01FE) begin n_fail++; $display("FAIL stuff_data got %h want 01fe", vq[0].data); end
    end
    n_checks++;
    if (eq.size() !== 0) begin n_fail++; $display("FAIL stuff_err got %0d pulses want 0", eq.size()); end
    $display("stuffing: FE 04 FE FE 01 FE 40 -> %0d valid pulses", vq.size());
  endtask

  task automatic test_framing_error();
    bq_t g = '{8'hFE, 8'h04, 8'h55, 8'hFE, 8'h40};
    int err_cyc;
    vq.delete(); eq.delete();
    send_byte(8'hFE, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'hAA, 1'b0);
    err_cyc = last_stop_cyc;
    send_byte(8'hBB, 1'b1);
    send_byte(8'hFE, 1'b1);
    send_byte(8'h40, 1'b1);
    idle(3);
    n_checks++;
    if (eq.size() !== 1) begin n_fail++; $display("FAIL ferr_count got %0d want 1", eq.size()); end
    else begin
      n_checks++;
      if (eq[0] !== err_cyc) begin n_fail++; $display("FAIL ferr_timing got cyc %0d want %0d", eq[0], err_cyc); end
    end
    n_checks++;
    if (vq.size() !== 0) begin n_fail++; $display("FAIL ferr_valid got %0d pulses want 0", vq.size()); end
    n_checks++;
    if ({bus.trans_stx_o, bus.trans_len_o} !== {8'h04, 5'd2} || bus.trans_data_o !== 128'h01FE) begin
      n_fail++;
      $display("FAIL ferr_hold got stx %h len %0d data %h want 04 2 01fe",
               bus.trans_stx_o, bus.trans_len_o, bus.trans_data_o);
    end
    vq.delete(); eq.delete();
    send_bytes(g);
    idle(3);
    n_checks++;
    if (vq.size() !== 1) begin n_fail++; $display("FAIL ferr_follow_count got %0d want 1", vq.size()); end
    else begin
      n_checks++;
      if (vq[0].stx !== 8'h04 || vq[0].len !== 5'd1 || vq[0].data !== 128'h55) begin
        n_fail++;
        $display("FAIL ferr_follow got stx %h len %0d data %h want 04 1 55", vq[0].stx, vq[0].len, vq[0].data);
      end
    end
    $display("framing_error: 1 bad stop bit, then a good frame");
  endtask

  task automatic test_overflow();
    int err_cyc = 0;
    vq.delete(); eq.delete();
    send_byte(8'hFE, 1'b1);
    send_byte(8'h05, 1'b1);
    for (int i = 0; i <= 16; i++) begin
      send_byte(8'(i), 1'b1);
      if (i == 16) err_cyc = last_stop_cyc;
    end
    send_byte(8'hFE, 1'b1);
    send_byte(8'h40, 1'b1);
    idle(3);
    n_checks++;
    if (eq.size() !== 1) begin n_fail++; $display("FAIL ovf_count got %0d want 1", eq.size()); end
    else begin
      n_checks++;
      if (eq[0] !== err_cyc) begin n_fail++; $display("FAIL ovf_timing got cyc %0d want %0d", eq[0], err_cyc); end
    end
    n_checks++;
    if (vq.size() !== 0) begin n_fail++; $display("FAIL ovf_valid got %0d pulses want 0", vq.size()); end
    $display("overflow: 17 payload bytes -> %0d error pulses", eq.size());
  endtask

  task automatic test_reset_mid_frame();
    bq_t g = '{8'hFE, 8'h05, 8'h77, 8'hFE, 8'h40};
    logic [7:0] b = 8'h22;
    vq.delete(); eq.delete();
    send_byte(8'hFE, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h11, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(b[i]);
    rst = 1'b1;
    send_bit(b[3]);
    rst = 1'b0;
    idle(12);
    n_checks++;
    if (vq.size() !== 0 || eq.size() !== 0) begin
      n_fail++;
      $display("FAIL rstmid_pulses got valid %0d err %0d want 0 0", vq.size(), eq.size());
    end
    n_checks++;
    if (bus.trans_stx_o !== 8'h00 || bus.trans_len_o !== 5'd0 || bus.trans_data_o !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got stx %h len %0d data %h want 0", bus.trans_stx_o, bus.trans_len_o, bus.trans_data_o);
    end
    send_bytes(g);
    idle(3);
    n_checks++;
    if (vq.size() !== 1) begin n_fail++; $display("FAIL rstmid_follow_count got %0d want 1", vq.size()); end
    else begin
      n_checks++;
      if (vq[0].stx !== 8'h05 || vq[0].len !== 5'd1 || vq[0].data !== 128'h77) begin
        n_fail++;
        $display("FAIL rstmid_follow got stx %h len %0d data %h want 05 1 77", vq[0].stx, vq[0].len, vq[0].data);
      end
    end
    $display("reset_mid_frame: aborted frame, then FE 05 77 FE 40");
  endtask

  task automatic test_back_to_back();
    bq_t p1 = '{8'hA1, 8'hA2};
    bq_t p2 = '{8'hB1, 8'hFE, 8'hB2, 8'hB3};
    bq_t f1, f2;
    f1 = build_frame(8'h05, p1);
    f2 = build_frame(8'h04, p2);
    vq.delete(); eq.delete();
    send_bytes(f1);
    send_bytes(f2);
    idle(3);
    n_checks++;
    if (vq.size() !== 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", vq.size()); end
    else begin
      n_checks++;
      if (vq[1].cyc - vq[0].cyc !== 10 * f2.size()) begin
        n_fail++;
        $display("FAIL b2b_gap got %0d want %0d", vq[1].cyc - vq[0].cyc, 10 * f2.size());
      end
      n_checks++;
      if (vq[0].stx !== 8'h05 || vq[0].len !== 5'd2 || vq[0].data !== pack_pl(p1)) begin
        n_fail++;
        $display("FAIL b2b_first got stx %h len %0d data %h", vq[0].stx, vq[0].len, vq[0].data);
      end
      n_checks++;
      if (vq[1].stx !== 8'h04 || vq[1].len !== 5'd4 || vq[1].data !== pack_pl(p2)) begin
        n_fail++;
        $display("FAIL b2b_second got stx %h len %0d data %h", vq[1].stx, vq[1].len, vq[1].data);
      end
    end
    n_checks++;
    if (eq.size() !== 0) begin n_fail++; $display("FAIL b2b_err got %0d pulses want 0", eq.size()); end
    $display("back_to_back: frames of %0d and %0d bytes, zero idle", f1.size(), f2.size());
  endtask

  task automatic test_random();
    bq_t pl, f;
    logic [7:0] stx;
    int len, stop_cyc;
    for (int it = 0; it < 24; it++) begin
      pl.delete();
      stx = ($urandom_range(0, 1) == 0) ? 8'h05 : 8'h04;
      len = $urandom_range(1, MP);
      for (int i = 0; i < len; i++)
        pl.push_back(($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom_range(0, 255)));
      f = build_frame(stx, pl);
      vq.delete(); eq.delete();
      idle($urandom_range(0, 3));
      send_bytes(f);
      stop_cyc = last_stop_cyc;
      idle(2);
      n_checks++;
      if (vq.size() !== 1 || eq.size() !== 0) begin
        n_fail++;
        $display("FAIL rand%0d_pulses got valid %0d err %0d want 1 0", it, vq.size(), eq.size());
      end else begin
        n_checks++;
        if (vq[0].stx !== stx || vq[0].len !== 5'(len)) begin
          n_fail++;
          $display("FAIL rand%0d_hdr got stx %h len %0d want %h %0d", it, vq[0].stx, vq[0].len, stx, len);
        end
        n_checks++;
        if (vq[0].data !== pack_pl(pl)) begin
          n_fail++;
          $display("FAIL rand%0d_data got %h want %h", it, vq[0].data, pack_pl(pl));
        end
        n_checks++;
        if (vq[0].cyc !== stop_cyc) begin
          n_fail++;
          $display("FAIL rand%0d_latency got cyc %0d want %0d", it, vq[0].cyc, stop_cyc);
        end
      end
      $display("random %0d: stx %h len %0d frame bytes %0d", it, stx, len, f.size());
    end
  endtask

  task automatic test_exclusive();
    n_checks++;
    if (both_cnt !== 0) begin n_fail++; $display("FAIL exclusive got %0d overlapping cycles want 0", both_cnt); end
  endtask

  initial begin
    bus.sbtx_i = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    test_reset();
    test_good_cmd();
    test_stuffing();
    test_framing_error();
    test_overflow();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
